// File: rtl/palette_layer_arbiter.sv
// palette_layer_arbiter
//
// Per-pixel front end. It shares one 12-bit palette lookup between four
// drawing layers and applies whole-screen fades to the palette's RGB output.
//
// Pipeline
//   stage 1 : priority/transparency arbitration -> RGB_12, pal_DrawX,
//             sel_layer, delayed blank_n
//   palette : external and combinational (pal_R/G/B follow RGB_12)
//   stage 2 : channel * fade_level >> 4, forced to 0 while blanking
//             -> VGA_R/G/B
//
// Fade sequencing
//   A frame tick fires on each falling edge of vs. While a fade is running,
//   every FRAMES_PER_STEP ticks is one step. A step moves fade_level by one
//   toward 0 (fade out) or toward 16 (fade in).
//
// Ports
//   Clk, Reset_n          pixel clock, synchronous active-low reset
//   layer_valid[3:0]      layer i covers the pixel (layer 0 has top priority)
//   layer_color[47:0]     layer i code at [12i+11:12i]
//   DrawX[9:0], blank_n   pixel column, low during blanking
//   vs                    vertical sync, active low
//   fade_out_req/in_req   one-cycle fade requests
//   RGB_12, pal_DrawX     registered palette address and aligned column
//   pal_R/G/B             palette result
//   VGA_R/G/B             registered final pixel
//   sel_layer             winning layer, 4 = none (aligned with RGB_12)
//   fade_level            0..16
//   fade_busy, fade_done  fade in progress / one-cycle completion pulse
//   fade_state            fade FSM state (0 IDLE, 1 FADE_OUT, 2 BLACK, 3 FADE_IN)
module palette_layer_arbiter #(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [3:0]  layer_valid,
  input  logic [47:0] layer_color,
  input  logic [9:0]  DrawX,
  input  logic        blank_n,
  input  logic        vs,
  input  logic        fade_out_req,
  input  logic        fade_in_req,
  output logic [11:0] RGB_12,
  output logic [9:0]  pal_DrawX,
  input  logic [7:0]  pal_R,
  input  logic [7:0]  pal_G,
  input  logic [7:0]  pal_B,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic [2:0]  sel_layer,
  output logic [4:0]  fade_level,
  output logic        fade_busy,
  output logic        fade_done,
  output logic [1:0]  fade_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    BLACK    = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_e;

  localparam logic [3:0] LAST_FRAME = 4'(FRAMES_PER_STEP - 1);
  localparam logic [4:0] LEVEL_FULL = 5'd16;

  // The palette draws these codes as the background gradient, so a layer
  // that carries one of them is treated as not covering the pixel.
  function automatic logic is_transparent(input logic [11:0] c);
    return (c == 12'h000) || (c == 12'h222) || (c == 12'h603) || (c == 12'h011);
  endfunction

  // The product fits in 13 bits (255 * 16). Level 16 returns x unchanged.
  function automatic logic [7:0] scale(input logic [7:0] x, input logic [4:0] lvl);
    return 8'(({5'd0, x} * {8'd0, lvl}) >> 4);
  endfunction

  // ---------------- stage 1: arbitration ----------------
  logic [11:0] win_code;
  logic [2:0]  win_sel;

  // The loop scans from layer 3 down to layer 0. A later match overwrites an
  // earlier one, so the lowest-numbered opaque layer wins.
  always_comb begin
    win_code = 12'h000;
    win_sel  = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (layer_valid[i] && !is_transparent(layer_color[12*i +: 12])) begin
        win_code = layer_color[12*i +: 12];
        win_sel  = 3'(i);
      end
    end
  end

  logic [11:0] rgb12_q;
  logic [9:0]  pal_drawx_q;
  logic [2:0]  sel_q;
  logic        blank_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rgb12_q     <= 12'h000;
      pal_drawx_q <= 10'd0;
      sel_q       <= 3'd4;
      blank_q     <= 1'b0;
    end else begin
      rgb12_q     <= win_code;
      pal_drawx_q <= DrawX;
      sel_q       <= win_sel;
      blank_q     <= blank_n;
    end
  end

  // ---------------- fade control ----------------
  fade_state_e state_q, state_d;
  logic [4:0]  level_q, level_d;
  logic        done_q, done_d;
  logic [3:0]  frame_cnt_q;
  logic        vs_prev_q;
  logic        frame_tick, step, busy, cnt_clr;
  logic        req_out, req_in;

  assign frame_tick = vs_prev_q & ~vs;
  assign busy       = (state_q == FADE_OUT) || (state_q == FADE_IN);
  assign step       = busy && frame_tick && (frame_cnt_q == LAST_FRAME);
  // When both requests arrive together, neither one takes effect.
  assign req_out    = fade_out_req & ~fade_in_req;
  assign req_in     = fade_in_req & ~fade_out_req;

  // A change of direction takes priority over a step in the same cycle.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_out) begin
          state_d = FADE_OUT;
          cnt_clr = 1'b1;
        end
      end
      FADE_OUT: begin
        if (req_in) begin
          state_d = FADE_IN;
          cnt_clr = 1'b1;
        end else if (step) begin
          if (level_q <= 5'd1) begin
            level_d = 5'd0;
            state_d = BLACK;
            done_d  = 1'b1;
          end else begin
            level_d = level_q - 5'd1;
          end
        end
      end
      BLACK: begin
        if (req_in) begin
          state_d = FADE_IN;
          cnt_clr = 1'b1;
        end
      end
      FADE_IN: begin
        if (req_out) begin
          state_d = FADE_OUT;
          cnt_clr = 1'b1;
        end else if (step) begin
          if (level_q >= 5'd15) begin
            level_d = LEVEL_FULL;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            level_d = level_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        level_d = LEVEL_FULL;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      level_q     <= LEVEL_FULL;
      done_q      <= 1'b0;
      frame_cnt_q <= 4'd0;
      vs_prev_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      done_q    <= done_d;
      vs_prev_q <= vs;
      if (cnt_clr) begin
        frame_cnt_q <= 4'd0;
      end else if (busy && frame_tick) begin
        frame_cnt_q <= (frame_cnt_q == LAST_FRAME) ? 4'd0 : frame_cnt_q + 4'd1;
      end
    end
  end

  // ---------------- stage 2: fade scaling ----------------
  logic [7:0] vga_r_q, vga_g_q, vga_b_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vga_r_q <= 8'd0;
      vga_g_q <= 8'd0;
      vga_b_q <= 8'd0;
    end else if (!blank_q) begin
      vga_r_q <= 8'd0;
      vga_g_q <= 8'd0;
      vga_b_q <= 8'd0;
    end else begin
      vga_r_q <= scale(pal_R, level_q);
      vga_g_q <= scale(pal_G, level_q);
      vga_b_q <= scale(pal_B, level_q);
    end
  end

  assign RGB_12     = rgb12_q;
  assign pal_DrawX  = pal_drawx_q;
  assign sel_layer  = sel_q;
  assign VGA_R      = vga_r_q;
  assign VGA_G      = vga_g_q;
  assign VGA_B      = vga_b_q;
  assign fade_level = level_q;
  assign fade_busy  = busy;
  assign fade_done  = done_q;
  assign fade_state = state_q;

endmodule

// File: tb/tb_palette_layer_arbiter.sv
module tb_palette_layer_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  layer_valid;
  logic [47:0] layer_color;
  logic [9:0]  DrawX;
  logic        blank_n;
  logic        vs;
  logic        fade_out_req;
  logic        fade_in_req;
  logic [11:0] RGB_12;
  logic [9:0]  pal_DrawX;
  logic [7:0]  pal_R, pal_G, pal_B;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic [2:0]  sel_layer;
  logic [4:0]  fade_level;
  logic        fade_busy;
  logic        fade_done;
  logic [1:0]  fade_state;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // Palette model: each nibble of the code becomes the high nibble of its channel.
  assign pal_R = {RGB_12[11:8], 4'h0};
  assign pal_G = {RGB_12[7:4], 4'h0};
  assign pal_B = {RGB_12[3:0], 4'h0};

  palette_layer_arbiter #(.FRAMES_PER_STEP(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .layer_valid(layer_valid), .layer_color(layer_color),
    .DrawX(DrawX), .blank_n(blank_n), .vs(vs), .fade_out_req(fade_out_req),
    .fade_in_req(fade_in_req), .RGB_12(RGB_12), .pal_DrawX(pal_DrawX),
    .pal_R(pal_R), .pal_G(pal_G), .pal_B(pal_B), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .sel_layer(sel_layer), .fade_level(fade_level),
    .fade_busy(fade_busy), .fade_done(fade_done), .fade_state(fade_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step_clk();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic frame_tick();
    vs = 1'b0;
    step_clk();
    if (fade_done) done_cnt++;
    vs = 1'b1;
    step_clk();
    if (fade_done) done_cnt++;
  endtask

  task automatic pulse_req(input logic out_r, input logic in_r);
    fade_out_req = out_r;
    fade_in_req  = in_r;
    step_clk();
    fade_out_req = 1'b0;
    fade_in_req  = 1'b0;
  endtask

  task automatic set_pixel(input logic [3:0] v, input logic [11:0] c0, input logic [11:0] c1,
                           input logic [11:0] c2, input logic [11:0] c3);
    layer_valid = v;
    layer_color = {c3, c2, c1, c0};
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset_n = 1'b0; layer_valid = 4'h0; layer_color = 48'h0; DrawX = 10'd0;
    blank_n = 1'b1; vs = 1'b1; fade_out_req = 1'b0; fade_in_req = 1'b0;
    step_clk();
    step_clk();
    chk("rst_rgb", 32'(RGB_12), 32'h0);
    chk("rst_drawx", 32'(pal_DrawX), 32'h0);
    chk("rst_sel", 32'(sel_layer), 32'd4);
    chk("rst_vga", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("rst_level", 32'(fade_level), 32'd16);
    chk("rst_busy", 32'(fade_busy), 32'd0);
    chk("rst_done", 32'(fade_done), 32'd0);
    chk("rst_state", 32'(fade_state), 32'd0);
    Reset_n = 1'b1;

    // layer 1 is transparent, so layer 2 wins
    set_pixel(4'b0110, 12'h000, 12'h222, 12'hb40, 12'h000);
    DrawX = 10'd123;
    step_clk();
    chk("arb_rgb_l2", 32'(RGB_12), 32'hb40);
    chk("arb_sel_l2", 32'(sel_layer), 32'd2);
    chk("arb_drawx", 32'(pal_DrawX), 32'd123);
    step_clk();
    chk("vga_l2", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00b04000);

    // layer 0 has top priority
    set_pixel(4'b1011, 12'habc, 12'hdef, 12'h123, 12'h456);
    step_clk();
    chk("arb_rgb_l0", 32'(RGB_12), 32'habc);
    chk("arb_sel_l0", 32'(sel_layer), 32'd0);

    // layers 0 and 2 are transparent and layer 1 is not valid, so layer 3 wins
    set_pixel(4'b1101, 12'h603, 12'h777, 12'h011, 12'h5a5);
    step_clk();
    chk("arb_rgb_l3", 32'(RGB_12), 32'h5a5);
    chk("arb_sel_l3", 32'(sel_layer), 32'd3);

    // every layer is transparent
    set_pixel(4'b1111, 12'h000, 12'h222, 12'h603, 12'h011);
    step_clk();
    chk("arb_rgb_none", 32'(RGB_12), 32'h000);
    chk("arb_sel_none", 32'(sel_layer), 32'd4);

    // blanking forces black
    set_pixel(4'b0001, 12'hfff, 12'h000, 12'h000, 12'h000);
    blank_n = 1'b0;
    step_clk();
    blank_n = 1'b1;
    chk("blank_rgb", 32'(RGB_12), 32'hfff);
    step_clk();
    chk("blank_vga", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    step_clk();
    chk("unblank_vga", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00f0f0f0);

    // requests that must be ignored in IDLE
    pulse_req(1'b0, 1'b1);
    chk("idle_in_state", 32'(fade_state), 32'd0);
    chk("idle_in_level", 32'(fade_level), 32'd16);
    pulse_req(1'b1, 1'b1);
    step_clk();
    chk("idle_both_state", 32'(fade_state), 32'd0);
    chk("idle_both_busy", 32'(fade_busy), 32'd0);
    chk("idle_both_level", 32'(fade_level), 32'd16);

    // full fade out
    set_pixel(4'b0001, 12'hf00, 12'h000, 12'h000, 12'h000);
    pulse_req(1'b1, 1'b0);
    chk("fo_state", 32'(fade_state), 32'd1);
    chk("fo_busy", 32'(fade_busy), 32'd1);
    done_cnt = 0;
    for (int i = 1; i <= 32; i++) begin
      frame_tick();
      chk("fo_level", 32'(fade_level), 32'(16 - i / 2));
      if (i == 16) chk("fo_vga_l8", {24'h0, VGA_R}, 32'h78);
    end
    chk("fo_done_cnt", 32'(done_cnt), 32'd1);
    chk("fo_black_state", 32'(fade_state), 32'd2);
    chk("fo_black_busy", 32'(fade_busy), 32'd0);
    chk("fo_black_vga", {24'h0, VGA_R}, 32'h0);

    // fade_out_req in BLACK is ignored
    pulse_req(1'b1, 1'b0);
    chk("black_out_state", 32'(fade_state), 32'd2);
    chk("black_out_level", 32'(fade_level), 32'd0);

    // fade in from black to level 9, then reset
    pulse_req(1'b0, 1'b1);
    chk("fi_state", 32'(fade_state), 32'd3);
    for (int i = 1; i <= 18; i++) frame_tick();
    chk("fi_level9", 32'(fade_level), 32'd9);
    Reset_n = 1'b0;
    step_clk();
    Reset_n = 1'b1;
    chk("mid_rst_level", 32'(fade_level), 32'd16);
    chk("mid_rst_busy", 32'(fade_busy), 32'd0);
    chk("mid_rst_state", 32'(fade_state), 32'd0);
    chk("mid_rst_vga", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("mid_rst_rgb", 32'(RGB_12), 32'h0);

    // fade out to level 5, then reverse
    pulse_req(1'b1, 1'b0);
    for (int i = 1; i <= 22; i++) begin
      frame_tick();
      chk("fo2_level", 32'(fade_level), 32'(16 - i / 2));
    end
    pulse_req(1'b0, 1'b1);
    chk("rev_state", 32'(fade_state), 32'd3);
    chk("rev_level", 32'(fade_level), 32'd5);
    frame_tick();
    chk("rev_tick1_level", 32'(fade_level), 32'd5);
    // This frame tick would be a step, but the request takes priority.
    vs = 1'b0;
    fade_out_req = 1'b1;
    step_clk();
    vs = 1'b1;
    fade_out_req = 1'b0;
    chk("coll_state", 32'(fade_state), 32'd1);
    chk("coll_level", 32'(fade_level), 32'd5);
    step_clk();
    pulse_req(1'b0, 1'b1);
    chk("fi2_state", 32'(fade_state), 32'd3);
    done_cnt = 0;
    for (int i = 1; i <= 22; i++) begin
      frame_tick();
      chk("fi2_level", 32'(fade_level), 32'(5 + i / 2));
    end
    chk("fi2_done_cnt", 32'(done_cnt), 32'd1);
    chk("fi2_state_idle", 32'(fade_state), 32'd0);
    chk("fi2_busy", 32'(fade_busy), 32'd0);
    chk("fi2_done_low", 32'(fade_done), 32'd0);
    chk("fi2_vga_full", {24'h0, VGA_R}, 32'hf0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
